nv_blkbox_src_bank: RTL and testbench
=====================================

# nv_blkbox_src_bank

Parametrised, programmable successor to the fixed constant-0 tie-off source cell. Drives NUM_CH independent WIDTH-bit constant outputs, used as ECO/spare tie-offs and strap values. Values are staged in shadow registers through a valid/ready config port and applied atomically by a delayed commit. An optional lock freezes them until reset. Sits in the vlibs blackbox layer and is instantiated wherever a tie-off must be adjustable post-silicon.

## Interface
- WIDTH, 8, bits per channel (≥1)
- NUM_CH, 4, channel count (≥1)
- CH_W, max(1,clog2(NUM_CH)), channel-index width
- RESET_VAL, {WIDTH{1'b0}}, per-channel reset value, applied to every channel
- COMMIT_DLY, 2, cycles the commit holds off before applying (≥1)
- nvdla_core_clk  input  1  sole clock; all state on rising edge
- nvdla_core_rstn  input  1  reset, asynchronous assert, active-low
- cfg_valid  input  1  config request valid
- cfg_ready  output  1  block can accept a request
- cfg_op  input  2  0 WRITE, 1 SET, 2 CLR, 3 COMMIT
- cfg_ch  input  CH_W  target channel (ignored for COMMIT)
- cfg_data  input  WIDTH  operand (ignored for COMMIT)
- lock_req  input  1  level; sampled high sets sticky lock
- Y  output  NUM_CH*WIDTH  active values; channel 0 in bits [WIDTH-1:0]
- commit_done  output  1  one-cycle pulse when Y takes committed values
- locked  output  1  sticky lock status
- err  output  1  sticky error flag

## Operation
- State per channel: shd[ch] (shadow), act[ch] (active). Y is the concatenation of act.
- FSM states IDLE and COMMIT. cfg_ready = (state==IDLE), driven from a register, not combinationally from cfg_valid.
- A request is accepted on an edge where cfg_valid && cfg_ready.
- Accepted ops, when unlocked and cfg_ch < NUM_CH:
  - WRITE: shd = cfg_data
  - SET: shd |= cfg_data
  - CLR: shd &= ~cfg_data
  - act and Y are unchanged by these ops.
- Accepted COMMIT when unlocked: IDLE→COMMIT and load counter to COMMIT_DLY.
  - In COMMIT, the counter decrements each cycle.
  - On the edge where the counter reaches 1: act[all] <= shd[all], state → IDLE, commit_done <= 1.
- Out-of-range cfg_ch (≥ NUM_CH) on ops 0–2: accepted, no state change, err <= 1.
- Any op accepted while locked: accepted, no state change, err <= 1.
- Lock: lock_req sampled high sets locked=1 on the next edge. Only reset clears it.
  - An op accepted on the same edge that lock_req is first sampled is performed normally.
  - A commit already in progress when lock sets completes normally.
- Shadow writes cannot occur during COMMIT because cfg_ready=0, so the committed snapshot is the shd content at acceptance.
- err is sticky; only reset clears it.
- Reset (async, any time, including mid-commit): shd=act=RESET_VAL for every channel, Y={NUM_CH{RESET_VAL}}, state IDLE, cfg_ready=1, commit_done=0, locked=0, err=0, counter=0. An aborted commit never applies.

## Timing
- WRITE/SET/CLR accepted at edge E: shd is updated after E. Y is unaffected. cfg_ready stays 1, so back-to-back ops are allowed every cycle.
- COMMIT accepted at edge E0:
  - cfg_ready=0 for cycles E0+1 … E0+COMMIT_DLY.
  - Y changes, commit_done=1 and cfg_ready=1 in the cycle after edge E0+COMMIT_DLY.
  - Total latency from acceptance to new Y is COMMIT_DLY+1 cycles (3 at default).
- commit_done is high for exactly one cycle per commit.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset with RESET_VAL=8'hA5, NUM_CH=4 -> Y=32'hA5A5A5A5, cfg_ready=1, commit_done=0, locked=0, err=0; also assert reset mid-commit -> same values, no commit_done.
- WRITE ch1=8'h3C, then SET ch1=8'h01, then CLR ch1=8'h04, then COMMIT (COMMIT_DLY=2) -> Y unchanged until the third cycle after COMMIT acceptance; then Y[15:8]=8'h39, commit_done pulse 1 cycle, cfg_ready low exactly 2 cycles.
- Hold cfg_valid with a WRITE during COMMIT -> not accepted until cfg_ready returns; the write then lands in shd only, Y still shows the committed value.
- WRITE cfg_ch=5 on NUM_CH=6, then cfg_ch=6 -> first updates shd[5], err stays 0; second sets err=1 with no shadow change.
- Assert lock_req in the same cycle as an accepted WRITE ch0=8'hFF, then COMMIT -> WRITE is applied to shd, locked=1 next cycle, COMMIT ignored, err=1, Y unchanged.
- Lock_req asserted during COMMIT -> commit completes with commit_done pulse, locked=1, and later WRITE is ignored with err=1.

Source files
------------

// File: rtl/nv_blkbox_src_bank_if.sv
// Config request channel for nv_blkbox_src_bank: valid/ready handshake plus op, channel and operand.
interface nv_blkbox_src_bank_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_op, output cfg_ch, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_op, input  cfg_ch, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/nv_blkbox_src_bank.sv
// Bank of programmable tie-off constants: shadow values staged over a config port,
// copied to the active outputs by a delayed atomic commit, optionally frozen by a sticky lock.
module nv_blkbox_src_bank #(
  parameter int               WIDTH      = 8,
  parameter int               NUM_CH     = 4,
  parameter int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               COMMIT_DLY = 2
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  nv_blkbox_src_bank_if.slave     cfg,
  input  logic                    lock_req,
  output logic [NUM_CH*WIDTH-1:0] Y,
  output logic                    commit_done,
  output logic                    locked,
  output logic                    err
);

  localparam int               CNT_W    = $clog2(COMMIT_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMMIT_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_SET    = 2'd1;
  localparam logic [1:0] OP_CLR    = 2'd2;
  localparam logic [1:0] OP_COMMIT = 2'd3;

  typedef enum logic {ST_IDLE, ST_COMMIT} state_t;

  state_t                          r_state;
  logic                            r_ready;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_done;
  logic                            r_locked;
  logic                            r_err;
  logic [NUM_CH-1:0][WIDTH-1:0]    r_shd;
  logic [NUM_CH-1:0][WIDTH-1:0]    r_act;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_ch_ok;
  logic             w_shd_we;
  logic             w_apply;
  logic             w_err_set;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] d);
    case (op)
      OP_SET:  apply_op = cur | d;
      OP_CLR:  apply_op = cur & ~d;
      default: apply_op = d;
    endcase
  endfunction

  assign w_accept = cfg.cfg_valid && r_ready;
  assign w_ch_ok  = (32'(cfg.cfg_ch) < 32'(NUM_CH));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shd_we    = 1'b0;
    w_apply     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (r_locked) begin
            w_err_set = 1'b1;
          end else if (cfg.cfg_op == OP_COMMIT) begin
            w_state_nxt = ST_COMMIT;
            w_cnt_nxt   = CNT_LOAD;
          end else if (w_ch_ok) begin
            w_shd_we = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        // A commit in flight ignores the lock; it always lands once started.
        if (r_cnt <= CNT_ONE) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shd[i] <= RESET_VAL;
        r_act[i] <= RESET_VAL;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= (w_state_nxt == ST_IDLE);
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_apply;
      r_locked <= r_locked | lock_req;
      r_err    <= r_err | w_err_set;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_shd_we && (cfg.cfg_ch == CH_W'(i)))
          r_shd[i] <= apply_op(cfg.cfg_op, r_shd[i], cfg.cfg_data);
        if (w_apply)
          r_act[i] <= r_shd[i];
      end
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign Y             = r_act;
  assign commit_done   = r_done;
  assign locked        = r_locked;
  assign err           = r_err;

endmodule

// File: tb/tb_nv_blkbox_src_bank.sv
// Randomized and directed bench for nv_blkbox_src_bank against a cycle-level reference model.
module tb_nv_blkbox_src_bank;

  localparam int             WIDTH  = 8;
  localparam int             NUM_CH = 6;
  localparam int             CH_W   = 3;
  localparam int             DLY    = 2;
  localparam logic [7:0]     RV     = 8'hA5;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b1;
  logic                     lock_req = 1'b0;
  logic [NUM_CH*WIDTH-1:0]  Y;
  logic                     commit_done;
  logic                     locked;
  logic                     err;

  nv_blkbox_src_bank_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  nv_blkbox_src_bank #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W), .RESET_VAL(RV), .COMMIT_DLY(DLY)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .cfg            (bus.slave),
    .lock_req       (lock_req),
    .Y              (Y),
    .commit_done    (commit_done),
    .locked         (locked),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: commit is a scheduled event at acceptance cycle + DLY.
  logic [7:0] shd_m [NUM_CH];
  logic [7:0] act_m [NUM_CH];
  logic       locked_m, err_m, done_m, ready_m, acc_m;
  int         cyc = 0;
  int         commit_at = -1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shd_m[i] = RV;
        act_m[i] = RV;
      end
      locked_m = 0; err_m = 0; done_m = 0; ready_m = 1; acc_m = 0; commit_at = -1;
    end else begin
      cyc++;
      acc_m  = ready_m && bus.cfg_valid;
      done_m = 0;
      if (commit_at == cyc) begin
        for (int i = 0; i < NUM_CH; i++) act_m[i] = shd_m[i];
        done_m    = 1;
        commit_at = -1;
      end
      if (acc_m) begin
        if (locked_m) err_m = 1;
        else if (bus.cfg_op == 2'd3) commit_at = cyc + DLY;
        else if (int'(bus.cfg_ch) >= NUM_CH) err_m = 1;
        else begin
          case (bus.cfg_op)
            2'd0: shd_m[bus.cfg_ch] = bus.cfg_data;
            2'd1: shd_m[bus.cfg_ch] = shd_m[bus.cfg_ch] | bus.cfg_data;
            default: shd_m[bus.cfg_ch] = shd_m[bus.cfg_ch] & ~bus.cfg_data;
          endcase
        end
      end
      if (lock_req) locked_m = 1;
      ready_m = (commit_at < 0);
    end
  end

  task automatic check_all();
    logic [NUM_CH*WIDTH-1:0] ey;
    for (int i = 0; i < NUM_CH; i++) ey[i*8 +: 8] = act_m[i];
    chk("Y", 64'(Y), 64'(ey));
    chk("cfg_ready", 64'(bus.cfg_ready), 64'(ready_m));
    chk("commit_done", 64'(commit_done), 64'(done_m));
    chk("locked", 64'(locked), 64'(locked_m));
    chk("err", 64'(err), 64'(err_m));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.cfg_valid = 1'b0;
    lock_req = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] ch, input logic [7:0] d);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = op;
    bus.cfg_ch    = ch;
    bus.cfg_data  = d;
    do begin
      tick();
      n++;
    end while (!acc_m && n < 20);
    bus.cfg_valid = 1'b0;
    chk("send_acc", 64'(acc_m), 64'd1);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_op    = 2'd0;
    bus.cfg_ch    = '0;
    bus.cfg_data  = '0;
    #2;
    do_reset();
    chk("rst_Y", 64'(Y), 64'h0000_A5A5A5A5A5A5);
    chk("rst_ready", 64'(bus.cfg_ready), 64'd1);
    chk("rst_done", 64'(commit_done), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    send(2'd0, 3'd1, 8'h3C);
    send(2'd1, 3'd1, 8'h01);
    send(2'd2, 3'd1, 8'h04);
    chk("pre_commit_ch1", 64'(Y[15:8]), 64'hA5);
    send(2'd3, 3'd0, 8'h00);
    chk("cm_ready_c1", 64'(bus.cfg_ready), 64'd0);
    chk("cm_Y_c1", 64'(Y[15:8]), 64'hA5);
    tick();
    chk("cm_ready_c2", 64'(bus.cfg_ready), 64'd0);
    chk("cm_Y_c2", 64'(Y[15:8]), 64'hA5);
    tick();
    chk("cm_Y_c3", 64'(Y[15:8]), 64'h39);
    chk("cm_done_c3", 64'(commit_done), 64'd1);
    chk("cm_ready_c3", 64'(bus.cfg_ready), 64'd1);
    tick();
    chk("cm_done_c4", 64'(commit_done), 64'd0);

    send(2'd3, 3'd0, 8'h00);
    send(2'd0, 3'd1, 8'h77);
    chk("hold_Y", 64'(Y[15:8]), 64'h39);
    tick();

    send(2'd0, 3'd5, 8'h5A);
    chk("ch5_err", 64'(err), 64'd0);
    send(2'd0, 3'd6, 8'hC3);
    chk("ch6_err", 64'(err), 64'd1);
    send(2'd3, 3'd0, 8'h00);
    tick(); tick();
    chk("ch5_Y", 64'(Y[47:40]), 64'h5A);
    chk("ch1_Y", 64'(Y[15:8]), 64'h77);

    do_reset();
    send(2'd0, 3'd2, 8'h12);
    send(2'd3, 3'd0, 8'h00);
    do_reset();
    chk("midrst_Y", 64'(Y), 64'h0000_A5A5A5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_done", 64'(commit_done), 64'd0);
    end

    lock_req = 1'b1;
    send(2'd0, 3'd0, 8'hFF);
    lock_req = 1'b0;
    chk("lk_locked", 64'(locked), 64'd1);
    send(2'd3, 3'd0, 8'h00);
    tick(); tick(); tick();
    chk("lk_err", 64'(err), 64'd1);
    chk("lk_Y", 64'(Y[7:0]), 64'hA5);

    do_reset();
    send(2'd0, 3'd2, 8'h11);
    send(2'd3, 3'd0, 8'h00);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    tick();
    chk("lkc_done", 64'(commit_done), 64'd1);
    chk("lkc_Y", 64'(Y[23:16]), 64'h11);
    chk("lkc_locked", 64'(locked), 64'd1);
    chk("lkc_err_pre", 64'(err), 64'd0);
    send(2'd0, 3'd2, 8'h22);
    tick();
    chk("lkc_err", 64'(err), 64'd1);
    chk("lkc_Y2", 64'(Y[23:16]), 64'h11);

    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        bus.cfg_valid = ($urandom_range(0, 3) != 0);
        bus.cfg_op    = 2'($urandom_range(0, 3));
        bus.cfg_ch    = 3'($urandom_range(0, 7));
        bus.cfg_data  = 8'($urandom);
        lock_req      = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    bus.cfg_valid = 1'b0;
    lock_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
